// File: rtl/mdu_pkg.sv
// Shared types for the MDU HI/LO controller: op and state encodings, divider timing, helpers.
// The optional multiply-accumulate ops are enabled with the MDU_ACCUM_EN macro.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MUL   = 4'd7,
        OP_MADD  = 4'd8,
        OP_MADDU = 4'd9,
        OP_MSUB  = 4'd10,
        OP_MSUBU = 4'd11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_ACC  = 2'd3
    } mdu_state_e;

    // Accept-to-commit cycles of a divide: load, 32 iterations, sign fix, commit.
    localparam int DIV_CYCLES = 34;

    function automatic logic op_is_signed(mdu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MUL) ||
               (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic [31:0] abs32(logic [31:0] x, logic is_signed);
        return (is_signed && x[31]) ? (32'd0 - x) : x;
    endfunction

endpackage

// File: rtl/mdu_hilo_ctrl_div.sv
// Iterative restoring divider: one load cycle, 32 shift/subtract steps, one sign-fix cycle.
// done pulses for one cycle with quotient/remainder valid; clear abandons the operation.
module mdu_div_iter
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [5:0] ITERS = 6'(DIV_CYCLES - 2);

    logic        run_q, run_d;
    logic        done_q, done_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [31:0] dvnd_q, dvnd_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        div0_q, div0_d;
    logic [32:0] shifted;
    logic [32:0] trial;

    always_comb begin
        run_d   = run_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        dvnd_d  = dvnd_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        div0_d  = div0_q;
        shifted = {rem_q, quot_q[31]};
        trial   = shifted - {1'b0, dvsr_q};

        if (clear) begin
            run_d = 1'b0;
        end else if (start) begin
            run_d   = 1'b1;
            cnt_d   = 6'd0;
            rem_d   = 32'd0;
            quot_d  = abs32(dividend, is_signed);
            dvsr_d  = abs32(divisor, is_signed);
            dvnd_d  = dividend;
            q_neg_d = is_signed && (dividend[31] ^ divisor[31]);
            r_neg_d = is_signed && dividend[31];
            div0_d  = (divisor == 32'd0);
        end else if (run_q) begin
            if (cnt_q != ITERS) begin
                // A clear borrow bit means the shifted partial remainder covered the divisor.
                if (!trial[32]) begin
                    rem_d  = trial[31:0];
                    quot_d = {quot_q[30:0], 1'b1};
                end else begin
                    rem_d  = shifted[31:0];
                    quot_d = {quot_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
            end else begin
                run_d  = 1'b0;
                done_d = 1'b1;
                if (div0_q) begin
                    quot_d = 32'hFFFF_FFFF;
                    rem_d  = dvnd_q;
                end else begin
                    quot_d = q_neg_q ? (32'd0 - quot_q) : quot_q;
                    rem_d  = r_neg_q ? (32'd0 - rem_q) : rem_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= 6'd0;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
            dvsr_q  <= 32'd0;
            dvnd_q  <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            run_q   <= run_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            dvnd_q  <= dvnd_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            div0_q  <= div0_d;
        end
    end

    assign busy      = run_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// MDU sequencer owning HI/LO: pipelined multiplier inline, iterative divider as sub-module.
// Define MDU_ACCUM_EN to enable MADD/MADDU/MSUB/MSUBU; otherwise those ops retire as no-ops.
module mdu_hilo_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  mdu_op_e     req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] mul_result,
    output mdu_state_e  dbg_state
);

    // Handshake: an op is taken on a rising edge where req_valid & req_ready & ~flush.
    // req_ready is high only in IDLE, so EX holds the op (and stalls) while busy is high.

    mdu_state_e  state_q, state_d;
    mdu_op_e     op_q, op_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] mul_res_q, mul_res_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] pipe_q [MUL_LAT];
    logic [63:0] pipe_d [MUL_LAT];
    logic [63:0] pipe_last;
    logic [63:0] mul_a, mul_b, mul_prod;
    logic        accept;
    logic        req_signed;
    logic        div_start, div_busy, div_done;
    logic [31:0] div_quot, div_rem;
`ifdef MDU_ACCUM_EN
    logic [63:0] prod_q, prod_d;
    logic [63:0] acc_sum;
`endif

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = ~req_ready;
    assign accept     = req_valid && req_ready && !flush;
    assign req_signed = op_is_signed(req_op);
    assign div_start  = accept && ((req_op == OP_DIV) || (req_op == OP_DIVU));

    // Low 64 bits of the 33x33 product are the same whether extended to 64 or 66 bits.
    assign mul_a     = {{32{req_signed && req_a[31]}}, req_a};
    assign mul_b     = {{32{req_signed && req_b[31]}}, req_b};
    assign mul_prod  = mul_a * mul_b;
    assign pipe_last = pipe_q[MUL_LAT-1];

    always_comb begin
        pipe_d = pipe_q;
        if (accept) pipe_d[0] = mul_prod;
        for (int i = 1; i < MUL_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

`ifdef MDU_ACCUM_EN
    assign acc_sum = ((op_q == OP_MSUB) || (op_q == OP_MSUBU)) ?
                     ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mul_res_d = mul_res_q;
        cnt_d     = cnt_q;
`ifdef MDU_ACCUM_EN
        prod_d    = prod_q;
`endif
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        case (req_op)
                            OP_MTHI: hi_d = req_a;
                            OP_MTLO: lo_d = req_a;
                            OP_MULT, OP_MULTU, OP_MUL: begin
                                state_d = S_MUL;
                                op_d    = req_op;
                                cnt_d   = 8'd0;
                            end
                            OP_DIV, OP_DIVU: begin
                                state_d = S_DIV;
                                op_d    = req_op;
                            end
                            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
`ifdef MDU_ACCUM_EN
                                state_d = S_MUL;
                                op_d    = req_op;
                                cnt_d   = 8'd0;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt_q == 8'(MUL_LAT - 1)) begin
                        case (op_q)
                            OP_MUL: begin
                                mul_res_d = pipe_last[31:0];
                                done_d    = 1'b1;
                                state_d   = S_IDLE;
                            end
`ifdef MDU_ACCUM_EN
                            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                                prod_d  = pipe_last;
                                state_d = S_ACC;
                            end
`endif
                            default: begin
                                {hi_d, lo_d} = pipe_last;
                                done_d       = 1'b1;
                                state_d      = S_IDLE;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_DIV: begin
                    if (div_done) begin
                        hi_d    = div_rem;
                        lo_d    = div_quot;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (!div_busy) begin
                        state_d = S_IDLE;
                    end
                end
`ifdef MDU_ACCUM_EN
                S_ACC: begin
                    {hi_d, lo_d} = acc_sum;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            op_q      <= OP_NONE;
            done_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            mul_res_q <= 32'd0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mul_res_q <= mul_res_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        pipe_q <= pipe_d;
`ifdef MDU_ACCUM_EN
        prod_q <= prod_d;
`endif
    end

    mdu_div_iter u_div (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (flush),
        .start     (div_start),
        .is_signed (req_signed),
        .dividend  (req_a),
        .divisor   (req_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    assign done       = done_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign mul_result = mul_res_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Directed bench for mdu_hilo_ctrl with MUL_LAT=2; MDU_ACCUM_EN selects the accumulate expectations.
module tb_mdu_hilo_ctrl;
    import mdu_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    mdu_op_e     req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] mul_result;
    mdu_state_e  dbg_state;

    int tests = 0;
    int fails = 0;
    int cyc;
    int seen;
    logic [31:0] exp_hi, exp_lo;

    always #5 clk = ~clk;

    mdu_hilo_ctrl #(.MUL_LAT(LAT)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .mul_result (mul_result),
        .dbg_state  (dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
        req_op    = OP_NONE;
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic run_quiet(input int n, output int s);
        s = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done !== 1'b0) s++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_op = OP_NONE;
        req_a = 32'd0; req_b = 32'd0; flush = 1'b0;
        repeat (3) tick();
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        chk("rst_mulres", {32'd0, mul_result}, 64'd0);
        resetn = 1'b1;
        tick();

        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        chk("mult_busy", {63'd0, busy}, 64'd1);
        wait_done(cyc);
        chk("mult_lat", 64'(cyc), 64'd2);
        chk("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mult_idle", {63'd0, busy}, 64'd0);
        tick();
        chk("mult_done_pulse", {63'd0, done}, 64'd0);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_done(cyc);
        chk("multu_hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);

        issue(OP_MUL, 32'd6, 32'd7);
        wait_done(cyc);
        chk("mul_lat", 64'(cyc), 64'd2);
        chk("mul_res", {32'd0, mul_result}, 64'd42);
        chk("mul_hilo_kept", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);

        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(cyc);
        chk("divu_lat", 64'(cyc), 64'd34);
        chk("divu_hilo", {hi_o, lo_o}, {32'd2, 32'd14});

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc);
        chk("div_neg_hilo", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        issue(OP_DIV, 32'd5, 32'd0);
        wait_done(cyc);
        chk("div0_hilo", {hi_o, lo_o}, {32'd5, 32'hFFFF_FFFF});

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc);
        chk("divovf_hilo", {hi_o, lo_o}, {32'd0, 32'h8000_0000});

        issue(OP_DIVU, 32'd50, 32'd3);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flushdiv_busy", {63'd0, busy}, 64'd0);
        chk("flushdiv_done", {63'd0, done}, 64'd0);
        chk("flushdiv_hilo", {hi_o, lo_o}, {32'd0, 32'h8000_0000});
        issue(OP_MTLO, 32'h0000_ABCD, 32'd0);
        chk("mtlo_after_flush", {hi_o, lo_o}, {32'd0, 32'h0000_ABCD});
        chk("mtlo_busy", {63'd0, busy}, 64'd0);
        run_quiet(40, seen);
        chk("flushdiv_no_late_done", 64'(seen), 64'd0);

        issue(OP_MTHI, 32'h0000_1234, 32'd0);
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
        chk("mthi_mtlo", {hi_o, lo_o}, {32'h0000_1234, 32'hFFFF_FFFF});
        issue(OP_MADDU, 32'd2, 32'd3);
`ifdef MDU_ACCUM_EN
        wait_done(cyc);
        chk("maddu_lat", 64'(cyc), 64'(LAT + 1));
        exp_hi = 32'h0000_1235; exp_lo = 32'h0000_0005;
        chk("maddu_hilo", {hi_o, lo_o}, {exp_hi, exp_lo});
        issue(OP_MSUB, 32'd2, 32'hFFFF_FFFF);
        wait_done(cyc);
        exp_lo = 32'h0000_0007;
        chk("msub_hilo", {hi_o, lo_o}, {exp_hi, exp_lo});
`else
        chk("maddu_noop_ready", {63'd0, req_ready}, 64'd1);
        run_quiet(6, seen);
        chk("maddu_noop_done", 64'(seen), 64'd0);
        exp_hi = 32'h0000_1234; exp_lo = 32'hFFFF_FFFF;
        chk("maddu_noop_hilo", {hi_o, lo_o}, {exp_hi, exp_lo});
`endif

        issue(OP_MULT, 32'd3, 32'd4);
        tick();
        chk("flushcmp_busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flushcmp_done", {63'd0, done}, 64'd0);
        chk("flushcmp_hilo", {hi_o, lo_o}, {exp_hi, exp_lo});
        chk("flushcmp_state", {62'd0, dbg_state}, {62'd0, S_IDLE});

        flush = 1'b1;
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        issue(OP_DIVU, 32'd9, 32'd3);
        flush = 1'b0;
        chk("drop_hi", {32'd0, hi_o}, {32'd0, exp_hi});
        chk("drop_busy", {63'd0, busy}, 64'd0);
        run_quiet(40, seen);
        chk("drop_no_done", 64'(seen), 64'd0);

        issue(OP_NONE, 32'd1, 32'd1);
        chk("none_busy", {63'd0, busy}, 64'd0);

        issue(OP_DIVU, 32'd9, 32'd3);
        repeat (5) tick();
        resetn = 1'b0;
        tick();
        chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
        chk("midrst_mulres", {32'd0, mul_result}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_ready", {63'd0, req_ready}, 64'd1);
        chk("midrst_done", {63'd0, done}, 64'd0);
        resetn = 1'b1;
        tick();
        issue(OP_DIVU, 32'd9, 32'd3);
        wait_done(cyc);
        chk("postrst_div_lat", 64'(cyc), 64'd34);
        chk("postrst_div_hilo", {hi_o, lo_o}, {32'd0, 32'd3});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
